// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared entry type and reset constants for the fetch queue.
package fetch_queue_pkg;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_q_entry_t;
   localparam logic [31:0] RESET_PC = 32'h80000000;
   localparam logic [31:0] NOP_INST = 32'h00000013;
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-side and decode-side handshake bundle of the fetch queue.
interface fetch_queue_if #(parameter int DEPTH = 4);
   logic flush, in_valid, req_stall, out_valid, out_ready, error;
   logic [31:0] in_pc, in_inst, out_pc, out_inst;
   logic [$clog2(DEPTH):0] count;
   modport master (
      output flush, in_valid, in_pc, in_inst, out_ready,
      input  req_stall, out_valid, out_pc, out_inst, count, error
   );
   modport slave (
      input  flush, in_valid, in_pc, in_inst, out_ready,
      output req_stall, out_valid, out_pc, out_inst, count, error
   );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction buffer between fetch and decode with early fetch throttling.
// Optional FETCH_QUEUE_BYPASS_EN adds a same-cycle in->out path when the queue is empty.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int SLACK = 2
) (
   input logic clk,
   input logic rst,
   fetch_queue_if.slave q
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [AW:0] FULL_CNT = CW'(DEPTH);
   localparam logic [AW:0] STALL_CNT = CW'(DEPTH - SLACK);
   fetch_q_entry_t mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0] cnt, cnt_next;
   logic empty, byp, valid, push, pop, pop_mem, wr_en, overflow, stall, err;
   always_comb begin
      empty = cnt == '0;
`ifdef FETCH_QUEUE_BYPASS_EN
      byp = empty && q.in_valid && !q.flush;
`else
      byp = 1'b0;
`endif
      valid = byp || !empty;
      push = q.in_valid && !q.flush;
      pop = valid && q.out_ready && !q.flush;
      pop_mem = pop && !empty;
      // a bypassed entry consumed in the same cycle never touches storage
      wr_en = push && (cnt != FULL_CNT || pop) && !(empty && pop);
      overflow = push && cnt == FULL_CNT && !pop;
      cnt_next = q.flush ? '0 : cnt + CW'(wr_en) - CW'(pop_mem);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt <= '0;
         stall <= 1'b0;
         err <= 1'b0;
      end else begin
         rd_ptr <= q.flush ? '0 : rd_ptr + AW'(pop_mem);
         wr_ptr <= q.flush ? '0 : wr_ptr + AW'(wr_en);
         cnt <= cnt_next;
         stall <= cnt_next >= STALL_CNT;
         err <= err || overflow;
      end
   end
   always_ff @(posedge clk)
      if (wr_en) mem[wr_ptr] <= '{pc: q.in_pc, inst: q.in_inst};
   assign q.out_valid = valid;
   assign q.out_pc = byp ? q.in_pc : empty ? RESET_PC : mem[rd_ptr].pc;
   assign q.out_inst = byp ? q.in_inst : empty ? NOP_INST : mem[rd_ptr].inst;
   assign q.count = cnt;
   assign q.req_stall = stall;
   assign q.error = err;
endmodule
